// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: ALU_op/funct decode, single-cycle logic/add/shift ops, iterative shift-add MUL.
// Define ALU_MULH_EN to add signed MULH (R-type funct 0000001001) with a 2*XLEN accumulator.
module alu_exec_unit #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_BITS = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [1:0]      ALU_op_i,
  input  logic [9:0]      funct_i,
  input  logic [XLEN-1:0] data1_i,
  input  logic [XLEN-1:0] data2_i,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o,
  output logic            illegal_o,
  output logic            busy_o
);

  localparam int unsigned SHW   = $clog2(XLEN);
  localparam int unsigned ITERS = XLEN / MUL_BITS;
  localparam int unsigned CNT_W = $clog2(ITERS + 1);
`ifdef ALU_MULH_EN
  localparam int unsigned ACC_W = 2 * XLEN;
`else
  localparam int unsigned ACC_W = XLEN;
`endif

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND, OP_MUL, OP_MULH
  } op_t;

  typedef enum logic [0:0] {ST_IDLE, ST_MUL} state_t;

  state_t state, next_state;
  op_t    op;
  logic   bad;
  logic   is_mul;
  logic   accept;
  logic   start_mul;
  logic   finish_mul;

  logic [XLEN-1:0]  alu_out;
  logic [SHW-1:0]   shamt;
  logic [ACC_W-1:0] mcand;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [XLEN-1:0]  mplier;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0]  mul_res;

`ifdef ALU_MULH_EN
  logic             neg;
  logic             high;
  logic [ACC_W-1:0] prod;
  logic [XLEN-1:0]  abs1;
  logic [XLEN-1:0]  abs2;
`endif

  always_comb begin
    op  = OP_ADD;
    bad = 1'b0;
    case (ALU_op_i)
      2'b00: op = OP_ADD;
      2'b01: op = OP_SUB;
      2'b11: begin
        case (funct_i[2:0])
          3'b000: op = OP_ADD;
          3'b001: op = OP_SLL;
          3'b010: op = OP_SLT;
          3'b011: begin op = OP_ADD; bad = 1'b1; end
          3'b100: op = OP_XOR;
          3'b101: op = funct_i[8] ? OP_SRA : OP_SRL;
          3'b110: op = OP_OR;
          default: op = OP_AND;
        endcase
      end
      default: begin
        case (funct_i)
          10'b0000000000: op = OP_ADD;
          10'b0100000000: op = OP_SUB;
          10'b0000001000: op = OP_MUL;
`ifdef ALU_MULH_EN
          10'b0000001001: op = OP_MULH;
`endif
          10'b0000000001: op = OP_SLL;
          10'b0000000010: op = OP_SLT;
          10'b0000000100: op = OP_XOR;
          10'b0000000101: op = OP_SRL;
          10'b0100000101: op = OP_SRA;
          10'b0000000110: op = OP_OR;
          10'b0000000111: op = OP_AND;
          default: begin op = OP_ADD; bad = 1'b1; end
        endcase
      end
    endcase
  end

  assign is_mul = (op == OP_MUL) || (op == OP_MULH);
  assign shamt  = data2_i[SHW-1:0];

  always_comb begin
    alu_out = '0;
    case (op)
      OP_SUB: alu_out = data1_i - data2_i;
      OP_SLL: alu_out = data1_i << shamt;
      OP_SLT: alu_out[0] = $signed(data1_i) < $signed(data2_i);
      OP_XOR: alu_out = data1_i ^ data2_i;
      OP_SRL: alu_out = data1_i >> shamt;
      OP_SRA: alu_out = $signed(data1_i) >>> shamt;
      OP_OR:  alu_out = data1_i | data2_i;
      OP_AND: alu_out = data1_i & data2_i;
      default: alu_out = data1_i + data2_i;
    endcase
  end

  always_comb begin
    acc_next = acc;
    for (int unsigned i = 0; i < MUL_BITS; i++) begin
      if (mplier[i]) acc_next = acc_next + (mcand << i);
    end
  end

`ifdef ALU_MULH_EN
  // MULH multiplies magnitudes and restores the sign at the end; MUL keeps raw operands.
  assign abs1 = data1_i[XLEN-1] ? ('0 - data1_i) : data1_i;
  assign abs2 = data2_i[XLEN-1] ? ('0 - data2_i) : data2_i;

  always_comb begin
    prod    = neg ? ('0 - acc_next) : acc_next;
    mul_res = high ? prod[ACC_W-1:XLEN] : prod[XLEN-1:0];
  end
`else
  assign mul_res = acc_next;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    ready_o    = 1'b0;
    start_mul  = 1'b0;
    finish_mul = 1'b0;
    case (state)
      ST_IDLE: begin
        ready_o = 1'b1;
        if (valid_i && is_mul) begin
          start_mul  = 1'b1;
          next_state = ST_MUL;
        end
      end
      default: begin
        if (count == CNT_W'(1)) begin
          finish_mul = 1'b1;
          next_state = ST_IDLE;
        end
      end
    endcase
  end

  assign accept = valid_i && ready_o;
  assign busy_o = !ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o   <= 1'b0;
      result_o  <= '0;
      zero_o    <= 1'b1;
      illegal_o <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      count     <= '0;
`ifdef ALU_MULH_EN
      neg       <= 1'b0;
      high      <= 1'b0;
`endif
    end else begin
      valid_o <= 1'b0;
      if (accept && !is_mul) begin
        valid_o   <= 1'b1;
        result_o  <= alu_out;
        zero_o    <= (alu_out == '0);
        illegal_o <= bad;
      end
      if (start_mul) begin
        acc   <= '0;
        count <= CNT_W'(ITERS);
`ifdef ALU_MULH_EN
        high <= (op == OP_MULH);
        if (op == OP_MULH) begin
          mcand  <= ACC_W'(abs1);
          mplier <= abs2;
          neg    <= data1_i[XLEN-1] ^ data2_i[XLEN-1];
        end else begin
          mcand  <= ACC_W'(data1_i);
          mplier <= data2_i;
          neg    <= 1'b0;
        end
`else
        mcand  <= data1_i;
        mplier <= data2_i;
`endif
      end
      if (state == ST_MUL) begin
        acc    <= acc_next;
        mcand  <= mcand << MUL_BITS;
        mplier <= mplier >> MUL_BITS;
        count  <= count - CNT_W'(1);
        if (finish_mul) begin
          valid_o   <= 1'b1;
          result_o  <= mul_res;
          zero_o    <= (mul_res == '0);
          illegal_o <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit (XLEN=32, MUL_BITS=1): directed steps plus randomized ops.
module tb_alu_exec_unit;

  localparam int XLEN     = 32;
  localparam int MUL_BITS = 1;
  localparam int MUL_LAT  = XLEN / MUL_BITS + 1;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [1:0]  ALU_op_i;
  logic [9:0]  funct_i;
  logic [31:0] data1_i;
  logic [31:0] data2_i;
  logic        valid_o;
  logic [31:0] result_o;
  logic        zero_o;
  logic        illegal_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  localparam logic [9:0] RT [12] = '{
    10'b0000000000, 10'b0100000000, 10'b0000001000, 10'b0000000001,
    10'b0000000010, 10'b0000000100, 10'b0000000101, 10'b0100000101,
    10'b0000000110, 10'b0000000111, 10'b0000001001, 10'b0000000011
  };

  alu_exec_unit #(.XLEN(XLEN), .MUL_BITS(MUL_BITS)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .ALU_op_i(ALU_op_i), .funct_i(funct_i), .data1_i(data1_i), .data2_i(data2_i),
    .valid_o(valid_o), .result_o(result_o), .zero_o(zero_o),
    .illegal_o(illegal_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: results straight from the operation table using plain arithmetic.
  task automatic ref_alu(input logic [1:0] aop, input logic [9:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic ill, output logic mul);
    int unsigned sh;
    logic [63:0] p;
    longint sa, sb;
    sh  = b % 32;
    ill = 1'b0;
    mul = 1'b0;
    r   = a + b;
    if (aop == 2'b01) r = a - b;
    else if (aop == 2'b11) begin
      case (f[2:0])
        3'd1: r = a << sh;
        3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: ill = 1'b1;
        3'd4: r = a ^ b;
        3'd5: r = f[8] ? 32'($signed(a) >>> sh) : (a >> sh);
        3'd6: r = a | b;
        3'd7: r = a & b;
        default: r = a + b;
      endcase
    end else if (aop == 2'b10) begin
      if (f == 10'b0100000000) r = a - b;
      else if (f == 10'b0000001000) begin
        p = 64'(a) * 64'(b); r = p[31:0]; mul = 1'b1;
      end
`ifdef ALU_MULH_EN
      else if (f == 10'b0000001001) begin
        sa = $signed(a); sb = $signed(b); p = sa * sb; r = p[63:32]; mul = 1'b1;
      end
`endif
      else if (f == 10'b0000000001) r = a << sh;
      else if (f == 10'b0000000010) r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      else if (f == 10'b0000000100) r = a ^ b;
      else if (f == 10'b0000000101) r = a >> sh;
      else if (f == 10'b0100000101) r = 32'($signed(a) >>> sh);
      else if (f == 10'b0000000110) r = a | b;
      else if (f == 10'b0000000111) r = a & b;
      else if (f != 10'b0000000000) ill = 1'b1;
    end
    sa = 0; sb = 0;
  endtask

  task automatic run_op(input logic [1:0] aop, input logic [9:0] f,
                        input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] er;
    logic ei, em;
    int lat, wc;
    ref_alu(aop, f, a, b, er, ei, em);
    ALU_op_i = aop; funct_i = f; data1_i = a; data2_i = b; valid_i = 1'b1;
    wc = 0;
    while (!ready_o && wc < 100) begin tick(); wc++; end
    check({tag, "_ready"}, {31'b0, ready_o}, 32'd1);
    tick();
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 100) begin tick(); lat++; end
    check({tag, "_lat"}, 32'(lat), em ? 32'(MUL_LAT) : 32'd1);
    check({tag, "_res"}, result_o, er);
    check({tag, "_zero"}, {31'b0, zero_o}, {31'b0, er == 32'd0});
    check({tag, "_ill"}, {31'b0, illegal_o}, {31'b0, ei});
    tick();
    check({tag, "_pulse"}, {31'b0, valid_o}, 32'd0);
    check({tag, "_hold"}, result_o, er);
  endtask

  initial begin
    int busy_cnt, early, pulses, idx;
    logic [1:0] aop;
    logic [9:0] f;
    logic [31:0] a, b;

    rst_i = 1'b1; valid_i = 1'b0; ALU_op_i = '0; funct_i = '0; data1_i = '0; data2_i = '0;
    tick(); tick();
    check("rst_ready", {31'b0, ready_o}, 32'd1);
    check("rst_valid", {31'b0, valid_o}, 32'd0);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_zero", {31'b0, zero_o}, 32'd1);
    check("rst_illegal", {31'b0, illegal_o}, 32'd0);
    rst_i = 1'b0;
    tick();

    run_op(2'b10, 10'b0100000000, 32'd5, 32'd7, "sub");
    check("sub_const", result_o, 32'hFFFF_FFFE);
    run_op(2'b01, 10'b0, 32'd9, 32'd9, "branch");
    check("branch_zero", {31'b0, zero_o}, 32'd1);
    run_op(2'b11, {7'b0100000, 3'b101}, 32'h8000_0000, 32'd4, "sra_imm");
    check("sra_const", result_o, 32'hF800_0000);
    run_op(2'b11, {7'b0, 3'b010}, 32'hFFFF_FFFF, 32'd1, "slt_imm");
    check("slt_const", result_o, 32'd1);
    run_op(2'b10, 10'b0000001001, 32'd3, 32'd4, "funct9");
`ifdef ALU_MULH_EN
    run_op(2'b10, 10'b0000001001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh");
    check("mulh_const", result_o, 32'd0);
`else
    check("illegal_const", result_o, 32'd7);
    check("illegal_flag", {31'b0, illegal_o}, 32'd1);
`endif

    // Back-to-back single-cycle accepts
    ALU_op_i = 2'b00; funct_i = '0; data1_i = 32'd100; data2_i = 32'd23; valid_i = 1'b1;
    tick();
    ALU_op_i = 2'b10; funct_i = 10'b0000000111; data1_i = 32'hF0F0; data2_i = 32'h0FF0;
    check("b2b_first_valid", {31'b0, valid_o}, 32'd1);
    check("b2b_first_res", result_o, 32'd123);
    tick();
    valid_i = 1'b0;
    check("b2b_second_valid", {31'b0, valid_o}, 32'd1);
    check("b2b_second_res", result_o, 32'h00F0);
    tick();

    // MUL with an ADD held on valid_i throughout
    ALU_op_i = 2'b10; funct_i = 10'b0000001000; data1_i = 32'h0001_0003; data2_i = 32'h0000_0005;
    valid_i = 1'b1;
    tick();
    ALU_op_i = 2'b00; funct_i = '0; data1_i = 32'h10; data2_i = 32'h20;
    check("mul_busy", {31'b0, busy_o}, 32'd1);
    busy_cnt = 0; early = 0;
    while (!ready_o && busy_cnt < 100) begin
      if (valid_o) early++;
      tick();
      busy_cnt++;
    end
    check("mul_busy_cycles", 32'(busy_cnt), 32'(XLEN / MUL_BITS));
    check("mul_no_early_valid", 32'(early), 32'd0);
    check("mul_valid", {31'b0, valid_o}, 32'd1);
    check("mul_res", result_o, 32'h0005_000F);
    check("mul_ill", {31'b0, illegal_o}, 32'd0);
    tick();
    valid_i = 1'b0;
    check("held_add_valid", {31'b0, valid_o}, 32'd1);
    check("held_add_res", result_o, 32'h30);
    tick();

    // Reset in the middle of a multiply
    ALU_op_i = 2'b10; funct_i = 10'b0000001000; data1_i = 32'd7; data2_i = 32'd9; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    repeat (9) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("abort_ready", {31'b0, ready_o}, 32'd1);
    check("abort_busy", {31'b0, busy_o}, 32'd0);
    check("abort_result", result_o, 32'd0);
    pulses = 0;
    repeat (40) begin
      if (valid_o) pulses++;
      tick();
    end
    check("abort_no_valid", 32'(pulses), 32'd0);

    // Randomized operations
    for (int n = 0; n < 50; n++) begin
      aop = 2'($urandom_range(0, 3));
      idx = $urandom_range(0, 12);
      if (aop == 2'b10) f = (idx == 12) ? 10'($urandom) : RT[idx];
      else f = 10'($urandom);
      case ($urandom_range(0, 3))
        0: a = 32'h8000_0000;
        1: a = 32'($urandom_range(0, 15));
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      run_op(aop, f, a, b, $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised execute-stage ALU that merges ALU control decode with a registered datapath.
- Decodes ALU_op/funct to an operation and executes it: single-cycle for logic, add and shift ops; iterative multi-cycle shift-add for MUL.
- Sits between ID/EX and EX/MEM.
- Uses a valid/ready handshake so the hazard unit can stall the front of the pipe while a multiply is in flight.

Parameters:
- XLEN, 32, operand/result width; power of two, 8 to 64.
- MUL_BITS, 1, multiplier bits retired per cycle; must divide XLEN (1, 2, 4).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous active-high reset.
- valid_i  in  1  operation presented this cycle.
- ready_o  out  1  unit can accept; valid_i && ready_o = accept.
- ALU_op_i  in  2  00 memory, 01 branch, 10 R-type, 11 immediate.
- funct_i  in  10  {funct7, funct3}.
- data1_i  in  XLEN  operand A.
- data2_i  in  XLEN  operand B (register or sign-extended immediate).
- valid_o  out  1  one-cycle pulse; result_o/zero_o/illegal_o valid.
- result_o  out  XLEN  registered result; held until the next valid_o.
- zero_o  out  1  result_o == 0; held with result_o.
- illegal_o  out  1  undecodable R-type funct; held with result_o.
- busy_o  out  1  multiply in progress (= !ready_o); drives the stall.

Behaviour:
- Reset (rst_i=1 at an edge): state IDLE, ready_o=1, valid_o=0, busy_o=0, result_o=0, zero_o=1, illegal_o=0, multiplier registers cleared.
  - Reset mid-multiply aborts the operation; no valid_o is produced.
- Decode:
  - ALU_op 00 -> ADD; 01 -> SUB.
  - 11 -> decode on funct3 only:
    - 000 ADD; 001 SLL; 010 SLT; 100 XOR; 101 SRL or SRA (funct7[5]=1 -> SRA); 110 OR; 111 AND.
    - 011 -> ADD with illegal_o=1.
  - 10 -> full 10-bit funct_i:
    - 0000000000 ADD; 0100000000 SUB; 0000001000 MUL; 0000000001 SLL; 0000000010 SLT.
    - 0000000100 XOR; 0000000101 SRL; 0100000101 SRA; 0000000110 OR; 0000000111 AND.
    - Any other value -> ADD result with illegal_o=1.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^XLEN.
  - Shift amount = data2_i[log2(XLEN)-1:0]; SRA replicates bit XLEN-1.
  - SLT is a signed compare; result is 1 or 0, zero-extended.
  - MUL returns the low XLEN bits of the product; identical for signed and unsigned operands.
- FSM, two states:
  - IDLE:
    - ready_o=1.
    - Accept of a non-MUL op: result registered at that edge; valid_o=1 in the following cycle (latency 1). Back-to-back accepts every cycle are allowed.
    - Accept of a MUL: latch operands, counter = XLEN/MUL_BITS, go to MUL.
  - MUL:
    - ready_o=0, busy_o=1.
    - Each cycle adds MUL_BITS partial products, shifts the multiplicand left and the multiplier right, decrements the counter.
    - When counter reaches 0: write result, valid_o=1, return to IDLE.
    - Total latency from accept edge to valid_o cycle = XLEN/MUL_BITS + 1.
    - valid_i during MUL is ignored, not queued; the producer must hold it.
- valid_o is never high for two cycles from one accept.
- Outputs hold between results.
- valid_o and ready_o can both be high in the same cycle; a new accept in that cycle is legal.

Optional Feature:
- ALU_MULH_EN defined:
  - R-type funct 0000001001 = MULH: signed x signed, returns the upper XLEN bits.
  - The multiplier keeps a 2*XLEN accumulator and sign-corrects operands.
  - Latency is the same as MUL.
- ALU_MULH_EN undefined:
  - 0000001001 decodes as illegal (ADD result, illegal_o=1).
  - Accumulator is XLEN wide.

Test Plan:
- Reset then idle: rst_i=1 for 2 cycles -> ready_o=1, valid_o=0, result_o=0, zero_o=1.
- R-type SUB, data1=5, data2=7 -> next cycle valid_o=1, result_o=0xFFFFFFFE, zero_o=0. Then branch op, 9 vs 9 -> result_o=0, zero_o=1.
- Immediate SRA, funct3=101, funct7[5]=1, data1=0x80000000, data2=4 -> result_o=0xF8000000. SLT with -1 vs 1 -> 1.
- MUL, XLEN=32, MUL_BITS=1, 0x0001_0003 x 0x0000_0005:
  - Expect ready_o=0 for 32 cycles and valid_o exactly 33 cycles after the accept edge.
  - result_o=0x0005_000F.
  - A valid_i ADD held during this time is accepted on the first ready_o cycle.
- Reset mid-MUL: assert rst_i 10 cycles after accept -> no valid_o ever, ready_o=1 the cycle after reset.
- R-type funct 0000001001 without ALU_MULH_EN, 3+4 -> result_o=7, illegal_o=1. With ALU_MULH_EN, 0xFFFFFFFF x 0xFFFFFFFF -> result_o=0x00000000.
